// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
// Holds the state encoding and the oversampling ratio.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity, stop.
// Bit timing comes from the shared 16x oversampling s_tick.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int SW =
    ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW =
    ($clog2(DBIT) > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] BIT_END  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST_BIT = NW'(DBIT - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  uart_state_t     state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            par, par_n;
  logic            done_n, tx_n, busy_n;

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    par_n   = par;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          state_n = START;
          s_n     = '0;
          b_n     = din;
          par_n   = (^din) ^ ODD;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == BIT_END) begin
            state_n = DATA;
            s_n     = '0;
            n_n     = '0;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == BIT_END) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == LAST_BIT)
              state_n = (PARITY_EN != 0) ? PARITY : STOP;
            else
              n_n = n + 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == BIT_END) begin
            state_n = STOP;
            s_n     = '0;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == STOP_END) begin
            state_n = IDLE;
            s_n     = '0;
            done_n  = 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is decoded from the state being entered so tx stays a flop.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = b_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      par          <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      par          <= par_n;
      tx           <= tx_n;
      tx_busy      <= busy_n;
      tx_done_tick <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations checked every cycle
// against a tick-counting frame model, plus literal frame checks.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic [1:0] tcnt = 2'd0;
  logic       start [3];
  logic [7:0] din   [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       done  [3];

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt   <= tcnt + 2'd1;
    s_tick <= (tcnt == 2'd3);
  end

  uart_tx_frame #(.DBIT(8), .SB_TICK(16),
    .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(start[0]), .din(din[0]),
    .tx_busy(busy[0]), .tx_done_tick(done[0]), .tx(tx[0]));

  uart_tx_frame #(.DBIT(8), .SB_TICK(16),
    .PARITY_EN(1), .PARITY_ODD(0)) dutp (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(start[1]), .din(din[1]),
    .tx_busy(busy[1]), .tx_done_tick(done[1]), .tx(tx[1]));

  uart_tx_frame #(.DBIT(7), .SB_TICK(32),
    .PARITY_EN(1), .PARITY_ODD(1)) dutq (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(start[2]), .din(din[2][6:0]),
    .tx_busy(busy[2]), .tx_done_tick(done[2]), .tx(tx[2]));

  function automatic int dbit_of(input int i);
    return (i == 2) ? 7 : 8;
  endfunction

  function automatic int flen(input int i);
    int pe;
    pe = (i != 0) ? 1 : 0;
    return (1 + dbit_of(i) + pe) * 16 + ((i == 2) ? 32 : 16);
  endfunction

  // Line level k ticks into a frame carrying word w.
  function automatic logic bitval(input int i,
      input logic [7:0] w, input int k);
    int idx;
    idx = k / 16;
    if (idx == 0) return 1'b0;
    if (idx <= dbit_of(i)) return w[idx-1];
    if (i != 0 && idx == dbit_of(i) + 1)
      return (^w) ^ (i == 2);
    return 1'b1;
  endfunction

  logic       m_act [3];
  int         m_k   [3];
  logic [7:0] m_w   [3];
  logic       e_tx  [3];
  logic       e_busy[3];
  logic       e_done[3];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_act[i]  <= 1'b0;
        m_k[i]    <= 0;
        m_w[i]    <= 8'h00;
        e_tx[i]   <= 1'b1;
        e_busy[i] <= 1'b0;
        e_done[i] <= 1'b0;
      end else begin
        e_done[i] <= 1'b0;
        if (!m_act[i]) begin
          if (start[i]) begin
            m_act[i]  <= 1'b1;
            m_k[i]    <= 0;
            m_w[i]    <= (i == 2) ? (din[i] & 8'h7F) : din[i];
            e_tx[i]   <= 1'b0;
            e_busy[i] <= 1'b1;
          end
        end else if (s_tick) begin
          if (m_k[i] + 1 == flen(i)) begin
            m_act[i]  <= 1'b0;
            e_done[i] <= 1'b1;
            e_busy[i] <= 1'b0;
            e_tx[i]   <= 1'b1;
          end else begin
            m_k[i]  <= m_k[i] + 1;
            e_tx[i] <= bitval(i, m_w[i], m_k[i] + 1);
          end
        end
      end
    end
  end

  task automatic chk(input string nm,
      input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h",
        nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tx%0d", i), 32'(tx[i]), 32'(e_tx[i]));
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(e_busy[i]));
        chk($sformatf("done%0d", i), 32'(done[i]), 32'(e_done[i]));
      end
    end
  end

  // Starts a frame on an s_tick edge so bit k spans clocks 64k..64k+63.
  task automatic run_frame(input int i, input logic [7:0] d,
      input int pulse_at, output logic [15:0] bits,
      output int dlat);
    int c;
    do @(posedge clk); while (!s_tick);
    repeat (4) @(negedge clk);
    din[i]   = d;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    c    = 0;
    dlat = -1;
    bits = '0;
    while (dlat < 0 && c < 3000) begin
      @(negedge clk);
      c++;
      if (c == pulse_at) begin
        start[i] = 1'b1;
        din[i]   = 8'hFF;
      end else if (c == pulse_at + 1) begin
        start[i] = 1'b0;
      end
      if (c % 64 == 32 && c < 1024) bits[c/64] = tx[i];
      if (done[i]) dlat = c;
    end
  endtask

  task automatic wait_done(input int i, output int ok);
    int c;
    c  = 0;
    ok = 0;
    while (!ok && c < 2000) begin
      @(negedge clk);
      c++;
      if (done[i]) ok = 1;
    end
  endtask

  logic [15:0] bits;
  int dlat, ok, nd;

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      din[i]   = 8'h00;
    end
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_tx", 32'(tx[0]), 1);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(0, 8'hA5, 0, bits, dlat);
    chk("a5_bits", 32'(bits[9:0]), 32'(10'b1101001010));
    chk("a5_lat", dlat, 640);

    run_frame(1, 8'h07, 0, bits, dlat);
    chk("even_par", 32'(bits[9]), 1);
    chk("even_bits", 32'(bits[10:0]), 32'(11'b11000001110));
    chk("even_lat", dlat, 704);

    run_frame(2, 8'h07, 0, bits, dlat);
    chk("odd_par", 32'(bits[8]), 0);
    chk("odd_bits", 32'(bits[10:0]), 32'(11'b11000001110));
    chk("odd_lat", dlat, 704);

    // Held tx_start: two frames with a single idle clock between them.
    @(negedge clk);
    din[0]   = 8'h55;
    start[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'hAA;
    wait_done(0, ok);
    chk("b2b_done1", ok, 1);
    chk("b2b_gap", 32'(busy[0]), 0);
    @(negedge clk);
    chk("b2b_restart", 32'(busy[0]), 1);
    chk("b2b_start_bit", 32'(tx[0]), 0);
    start[0] = 1'b0;
    wait_done(0, ok);
    chk("b2b_done2", ok, 1);

    run_frame(0, 8'h3C, 200, bits, dlat);
    chk("ign_bits", 32'(bits[9:0]), 32'(10'b1001111000));
    chk("ign_lat", dlat, 640);
    repeat (800) @(negedge clk);
    chk("ign_noframe", 32'(busy[0]), 0);

    // Reset in the middle of data bit 3.
    din[0]   = 8'h5A;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (288) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_tx", 32'(tx[0]), 1);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_done", 32'(done[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(0, 8'h96, 0, bits, dlat);
    chk("clean_bits", 32'(bits[9:0]), 32'(10'b1100101100));
    chk("clean_lat", dlat, 640);

    nd = 0;
    for (int w = 0; w < 40; w++) begin
      din[2]   = 8'($urandom);
      start[2] = 1'b1;
      @(negedge clk);
      start[2] = 1'b0;
      wait_done(2, ok);
      nd += ok;
    end
    chk("rand_frames", nd, 40);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
